// File: rtl/knn_pkg.sv
// Shared KNN types: controller state encoding and the vote-counter width helper.
package knn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SELECT = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width that holds vote counts 0..k without overflow.
  function automatic int cnt_w(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/knn_majority_vote_if.sv
// Sorted-vector input and class-label output bundle between the sorter path and the voter.
interface knn_majority_vote_if #(
  parameter int L      = 5,
  parameter int W      = 16,
  parameter int TYPE_W = 3
);
  localparam int N = 1 << L;

  logic                in_valid;
  logic                ascending;
  logic [W*N-1:0]      in;
  logic [TYPE_W*N-1:0] in_type;
  logic [TYPE_W-1:0]   out_class;
  logic                out_valid;
  logic                busy;
  logic                drop;

  modport master (
    output in_valid, ascending, in, in_type,
    input  out_class, out_valid, busy, drop
  );

  modport slave (
    input  in_valid, ascending, in, in_type,
    output out_class, out_valid, busy, drop
  );
endinterface

// File: rtl/knn_argmax_step.sv
// One step of the class scan: decides whether the candidate class replaces the running best.
// Distance-sum tie break is compiled in with KNN_VOTE_DIST_TIE_EN.
module knn_argmax_step #(
  parameter int CNT_W  = 3,
  parameter int SUM_W  = 19,
  parameter int TYPE_W = 3
) (
  input  logic              first,
  input  logic [CNT_W-1:0]  cand_cnt,
  input  logic [SUM_W-1:0]  cand_sum,
  input  logic [TYPE_W-1:0] cand_cls,
  input  logic [CNT_W-1:0]  best_cnt,
  input  logic [SUM_W-1:0]  best_sum,
  input  logic [TYPE_W-1:0] best_cls,
  output logic [CNT_W-1:0]  win_cnt,
  output logic [SUM_W-1:0]  win_sum,
  output logic [TYPE_W-1:0] win_cls
);
  logic take_s;

  // Strictly better count wins; otherwise the lower class index already held is kept.
  always_comb begin
    take_s = 1'b0;
    if (first) begin
      take_s = 1'b1;
    end else if (cand_cnt > best_cnt) begin
      take_s = 1'b1;
`ifdef KNN_VOTE_DIST_TIE_EN
    end else if ((cand_cnt == best_cnt) && (cand_sum < best_sum)) begin
      take_s = 1'b1;
`endif
    end else begin
      take_s = 1'b0;
    end
  end

  assign win_cnt = take_s ? cand_cnt : best_cnt;
  assign win_sum = take_s ? cand_sum : best_sum;
  assign win_cls = take_s ? cand_cls : best_cls;
endmodule

// File: rtl/knn_majority_vote.sv
// Majority vote over the K nearest sorted entries: capture, K count cycles, C scan cycles.
// Optional macro KNN_VOTE_DIST_TIE_EN breaks vote ties by the smaller per-class distance sum.
module knn_majority_vote
  import knn_pkg::*;
#(
  parameter int L      = 5,
  parameter int W      = 16,
  parameter int TYPE_W = 3,
  parameter int K      = 5
) (
  input logic                clk,
  input logic                rst,
  knn_majority_vote_if.slave bus
);
  localparam int N     = 1 << L;
  localparam int C     = 1 << TYPE_W;
  localparam int CNT_W = cnt_w(K);
  localparam int SUM_W = W + CNT_W;

  typedef logic [TYPE_W-1:0] cls_t;
  typedef logic [W-1:0]      dist_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [SUM_W-1:0]  sum_t;

  localparam cnt_t K_LAST = cnt_t'(K - 1);
  localparam cls_t C_LAST = {TYPE_W{1'b1}};

  if ((K < 1) || (K > N)) begin : g_k_range
    $error("knn_majority_vote: K must lie in 1..N");
  end

  // Lane slicing shared with the sorter: entry i occupies bits [w*(i+1)-1 : w*i].
  function automatic cls_t lane_type(input logic [TYPE_W*N-1:0] v, input int i);
    return cls_t'(v >> (i * TYPE_W));
  endfunction

  state_t state_r, state_s;
  cls_t   type_sh_r [K];
  cnt_t   cnt_r [C];
  cnt_t   k_idx_r, best_cnt_r, win_cnt_s;
  cls_t   c_idx_r, best_cls_r, win_cls_s, out_class_r;
  sum_t   cand_sum_s, best_sum_s, win_sum_s;
  logic   out_valid_r, busy_r, drop_r;
  logic   out_valid_s, busy_s, drop_s, accept_s, first_s;

`ifdef KNN_VOTE_DIST_TIE_EN
  function automatic dist_t lane_dist(input logic [W*N-1:0] v, input int i);
    return dist_t'(v >> (i * W));
  endfunction

  dist_t dist_sh_r [K];
  sum_t  sum_r [C];
  sum_t  best_sum_r;

  assign cand_sum_s = sum_r[c_idx_r];
  assign best_sum_s = best_sum_r;
`else
  logic unused_s;

  assign cand_sum_s = {SUM_W{1'b0}};
  assign best_sum_s = {SUM_W{1'b0}};
  assign unused_s   = ^{win_sum_s, bus.in};
`endif

  assign accept_s = bus.in_valid && ((state_r == IDLE) || (state_r == DONE));
  assign first_s  = (c_idx_r == {TYPE_W{1'b0}});

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic; DONE doubles as an accept slot for back-to-back vectors.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.in_valid) state_s = COUNT; else state_s = IDLE;
      COUNT:   if (k_idx_r == K_LAST) state_s = SELECT; else state_s = COUNT;
      SELECT:  if (c_idx_r == C_LAST) state_s = DONE; else state_s = SELECT;
      DONE:    if (bus.in_valid) state_s = COUNT; else state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the next state so the flags land registered in the matching cycle.
  always_comb begin
    busy_s      = (state_s == COUNT) || (state_s == SELECT);
    out_valid_s = (state_s == DONE);
    drop_s      = bus.in_valid && ((state_r == COUNT) || (state_r == SELECT));
  end

  knn_argmax_step #(
    .CNT_W (CNT_W),
    .SUM_W (SUM_W),
    .TYPE_W(TYPE_W)
  ) u_step (
    .first   (first_s),
    .cand_cnt(cnt_r[c_idx_r]),
    .cand_sum(cand_sum_s),
    .cand_cls(c_idx_r),
    .best_cnt(best_cnt_r),
    .best_sum(best_sum_s),
    .best_cls(best_cls_r),
    .win_cnt (win_cnt_s),
    .win_sum (win_sum_s),
    .win_cls (win_cls_s)
  );

  // Capture, vote counting, class scan and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) type_sh_r[i] <= '0;
      for (int c = 0; c < C; c++) cnt_r[c] <= '0;
      k_idx_r     <= '0;
      c_idx_r     <= '0;
      best_cnt_r  <= '0;
      best_cls_r  <= '0;
      out_class_r <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      drop_r      <= 1'b0;
`ifdef KNN_VOTE_DIST_TIE_EN
      for (int i = 0; i < K; i++) dist_sh_r[i] <= '0;
      for (int c = 0; c < C; c++) sum_r[c] <= '0;
      best_sum_r <= '0;
`endif
    end else begin
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      drop_r      <= drop_s;
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            // Nearest entry goes to the head of the shift register.
            for (int i = 0; i < K; i++)
              type_sh_r[i] <= lane_type(bus.in_type, bus.ascending ? i : (N - 1 - i));
            for (int c = 0; c < C; c++) cnt_r[c] <= '0;
            k_idx_r <= '0;
            c_idx_r <= '0;
`ifdef KNN_VOTE_DIST_TIE_EN
            for (int i = 0; i < K; i++)
              dist_sh_r[i] <= lane_dist(bus.in, bus.ascending ? i : (N - 1 - i));
            for (int c = 0; c < C; c++) sum_r[c] <= '0;
`endif
          end
        end
        COUNT: begin
          cnt_r[type_sh_r[0]] <= cnt_r[type_sh_r[0]] + cnt_t'(1'b1);
          for (int i = 0; i < K - 1; i++) type_sh_r[i] <= type_sh_r[i + 1];
          k_idx_r <= k_idx_r + cnt_t'(1'b1);
`ifdef KNN_VOTE_DIST_TIE_EN
          sum_r[type_sh_r[0]] <= sum_r[type_sh_r[0]] + sum_t'(dist_sh_r[0]);
          for (int i = 0; i < K - 1; i++) dist_sh_r[i] <= dist_sh_r[i + 1];
`endif
        end
        SELECT: begin
          best_cnt_r <= win_cnt_s;
          best_cls_r <= win_cls_s;
          c_idx_r    <= c_idx_r + cls_t'(1'b1);
          if (c_idx_r == C_LAST) out_class_r <= win_cls_s;
`ifdef KNN_VOTE_DIST_TIE_EN
          best_sum_r <= win_sum_s;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.out_class = out_class_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.drop      = drop_r;
endmodule
